// File: rtl/wave_pkg.sv
// Shared constants and helpers for the multi-channel waveform renderer.
package wave_pkg;

    localparam int COL_W   = 8;
    localparam int COLOR_W = 24;
    localparam logic [7:0] MID_Y = 8'd128;

    // Colour field offsets within a packed {r,g,b} word
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        SCALE_DIV2     = 2'd0,
        SCALE_DIV4     = 2'd1,
        SCALE_DIV8     = 2'd2,
        SCALE_DIV8_ALT = 2'd3
    } scale_e;

    localparam logic [1:0] SHIFT_MAX = 2'd2;

    // Encoding 3 aliases the deepest supported shift.
    function automatic logic [1:0] eff_shift(input logic [1:0] s);
        return (s == SCALE_DIV8_ALT) ? SHIFT_MAX : s;
    endfunction

endpackage

// File: rtl/wave_channel.sv
// One trace: scales the RAM sample, keeps the current/previous segment
// endpoints and decides whether the current row is hit.
module wave_channel
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int Y_OFFSET = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [1:0]          scale,
    input  logic                capture,
    input  logic [7:0]          yv,
    input  logic                in_window,
    input  logic                enable,
    input  logic                fill,
    output logic                draw
);

    logic [SAMPLE_W-1:0] shifted;
    logic [7:0]          adj;
    logic [7:0]          curr;
    logic [7:0]          prev;
    logic                line_hit;
    logic                fill_hit;
    logic                hit;

    always_comb begin
        shifted = sample >> (eff_shift(scale) + 2'd1);
        adj     = 8'(shifted) + 8'(Y_OFFSET);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            curr <= '0;
            prev <= '0;
        end else if (capture) begin
            curr <= adj;
            prev <= curr;
        end
    end

    always_comb begin
        line_hit = ((prev <= yv) && (yv <= curr)) ||
                   ((curr <= yv) && (yv <= prev));
        fill_hit = ((MID_Y <= yv) && (yv <= curr)) ||
                   ((curr <= yv) && (yv <= MID_Y));
        hit      = fill ? fill_hit : line_hit;
        draw     = enable & in_window & hit;
    end

endmodule

// File: rtl/wave_display_mc.sv
// Multi-channel waveform overlay: address generation, capture timing,
// per-channel hit detection, priority colour mux and registered pixel output.
module wave_display_mc
    import wave_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 8,
    parameter int Y_OFFSET = 32,
    parameter int COL_LO   = 3,
    parameter int COL_HI   = 252
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [10:0]                  x,
    input  logic [9:0]                   y,
    input  logic                         valid,
    input  logic                         read_index,
    input  logic [NUM_CH*SAMPLE_W-1:0]   read_value,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            ch_fill,
    input  logic [1:0]                   scale,
    input  logic [NUM_CH*COLOR_W-1:0]    ch_color,
    output logic [8:0]                   read_address,
    output logic                         valid_pixel,
    output logic [7:0]                   r,
    output logic [7:0]                   g,
    output logic [7:0]                   b
);

    localparam logic [COL_W-1:0] COL_LO_C = COL_W'(COL_LO);
    localparam logic [COL_W-1:0] COL_HI_C = COL_W'(COL_HI);

    logic [COL_W-1:0]   col;
    logic [7:0]         yv;
    logic               in_window;
    logic [8:0]         prev_addr;
    logic               chg;
    logic               chg_q;
    logic [NUM_CH-1:0]  draw;
    logic [COLOR_W-1:0] win_color;
    logic               found;
    logic               unused_bits;

    assign read_address = {read_index, x[9], x[7:1]};
    assign unused_bits  = ^{x[10], x[0], y[0]};

    always_comb begin
        col       = {x[9], x[7:1]};
        yv        = y[8:1];
        in_window = valid
                  && ((x[9:8] == 2'b01) || (x[9:8] == 2'b10))
                  && !y[9]
                  && (col >= COL_LO_C) && (col <= COL_HI_C);
        chg       = (read_address != prev_addr);
    end

    // RAM data trails the address by a cycle, so capture on the delayed change flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_addr <= '0;
            chg_q     <= 1'b0;
        end else begin
            prev_addr <= read_address;
            chg_q     <= chg;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wave_channel #(
            .SAMPLE_W (SAMPLE_W),
            .Y_OFFSET (Y_OFFSET)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .sample    (read_value[c*SAMPLE_W +: SAMPLE_W]),
            .scale     (scale),
            .capture   (chg_q),
            .yv        (yv),
            .in_window (in_window),
            .enable    (ch_enable[c]),
            .fill      (ch_fill[c]),
            .draw      (draw[c])
        );
    end

    // Lowest-index drawing channel wins.
    always_comb begin
        win_color = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (draw[i] && !found) begin
                found     = 1'b1;
                win_color = ch_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pixel <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            valid_pixel <= found;
            r           <= win_color[R_LSB +: 8];
            g           <= win_color[G_LSB +: 8];
            b           <= win_color[B_LSB +: 8];
        end
    end

endmodule

// File: tb/tb_wave_display_mc.sv
// Directed-vector bench for wave_display_mc with hand-computed expectations.
module tb_wave_display_mc;

    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [10:0]                x;
    logic [9:0]                 y;
    logic                       valid;
    logic                       read_index;
    logic [NUM_CH*SAMPLE_W-1:0] read_value;
    logic [NUM_CH-1:0]          ch_enable;
    logic [NUM_CH-1:0]          ch_fill;
    logic [1:0]                 scale;
    logic [NUM_CH*24-1:0]       ch_color;
    logic [8:0]                 read_address;
    logic                       valid_pixel;
    logic [7:0]                 r, g, b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    wave_display_mc #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .Y_OFFSET (32),
        .COL_LO   (3),
        .COL_HI   (252)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .valid        (valid),
        .read_index   (read_index),
        .read_value   (read_value),
        .ch_enable    (ch_enable),
        .ch_fill      (ch_fill),
        .scale        (scale),
        .ch_color     (ch_color),
        .read_address (read_address),
        .valid_pixel  (valid_pixel),
        .r            (r),
        .g            (g),
        .b            (b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a new column with its sample, wait for the capture to land.
    task automatic load(input logic [10:0] xv, input logic [15:0] rv);
        x          = xv;
        read_value = rv;
        valid      = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; x = '0; y = '0; valid = 1'b1; read_index = 1'b0;
        read_value = '0; ch_enable = '0; ch_fill = '0; scale = '0; ch_color = '0;
        step();
        step();
        vectors++;
        if (valid_pixel !== 1'b0 || {r, g, b} !== 24'h0) begin
            errors++;
            $display("FAIL reset_out: got valid=%0b rgb=%06h, expected 0/000000", valid_pixel, {r, g, b});
        end
        vectors++;
        if (read_address !== 9'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d, expected 0", read_address);
        end
        x = 11'd278; read_index = 1'b1;
        #1;
        vectors++;
        if (read_address !== 9'd267) begin
            errors++;
            $display("FAIL addr_map: got %0d, expected 267", read_address);
        end
        read_index = 1'b0; x = '0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_line();
        ch_enable = 2'b01; ch_fill = 2'b00; scale = 2'd0;
        ch_color  = {24'hABCDEF, 24'h123456};
        load(11'd276, {8'd0, 8'd64});
        load(11'd278, {8'd0, 8'd128});
        y = 10'd160; valid = 1'b0;
        step();
        valid = 1'b1;
        #2;
        vectors++;
        if (valid_pixel !== 1'b0) begin
            errors++;
            $display("FAIL line_latency_early: got valid=%0b, expected 0", valid_pixel);
        end
        step();
        vectors++;
        if (valid_pixel !== 1'b1) begin
            errors++;
            $display("FAIL line_latency: got valid=%0b, expected 1", valid_pixel);
        end
        for (int yv = 60; yv <= 100; yv++) begin
            logic        ev;
            logic [23:0] ec;
            y  = 10'(2 * yv + (yv % 2));
            ev = (yv >= 64) && (yv <= 96);
            ec = ev ? 24'h123456 : 24'h0;
            step();
            vectors++;
            if (valid_pixel !== ev || {r, g, b} !== ec) begin
                errors++;
                $display("FAIL line_scan yv=%0d: got valid=%0b rgb=%06h, expected valid=%0b rgb=%06h",
                         yv, valid_pixel, {r, g, b}, ev, ec);
            end
        end
    endtask

    task automatic test_priority();
        logic [1:0]  ens  [4];
        logic [23:0] exps [4];
        ch_enable = 2'b11; ch_fill = 2'b00; scale = 2'd0;
        ch_color  = {24'h00FF00, 24'hFF0000};
        load(11'd296, {8'd64, 8'd64});
        load(11'd298, {8'd128, 8'd128});
        ens  = '{2'b11, 2'b10, 2'b00, 2'b01};
        exps = '{24'hFF0000, 24'h00FF00, 24'h000000, 24'h0000FF};
        y = 10'd160; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch_enable = ens[i];
            if (i == 3) ch_color = {24'h00FF00, 24'h0000FF};
            step();
            vectors++;
            if (valid_pixel !== (ens[i] != 2'b00) || {r, g, b} !== exps[i]) begin
                errors++;
                $display("FAIL priority en=%02b: got valid=%0b rgb=%06h, expected rgb=%06h",
                         ens[i], valid_pixel, {r, g, b}, exps[i]);
            end
        end
    endtask

    task automatic test_fill();
        int   yv0 [5];
        logic ev0 [5];
        int   yv2 [5];
        logic ev2 [5];
        yv0 = '{127, 128, 130, 132, 133};
        ev0 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        yv2 = '{56, 57, 100, 128, 129};
        ev2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ch_enable = 2'b01; ch_fill = 2'b01; scale = 2'd0;
        load(11'd316, {8'd0, 8'd200});
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            y = 10'(2 * yv0[i]);
            step();
            vectors++;
            if (valid_pixel !== ev0[i]) begin
                errors++;
                $display("FAIL fill_s0 yv=%0d: got valid=%0b, expected %0b", yv0[i], valid_pixel, ev0[i]);
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            scale = (pass == 0) ? 2'd2 : 2'd3;
            load(11'(318 + 2 * pass), {8'd0, 8'd200});
            valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                y = 10'(2 * yv2[i]);
                step();
                vectors++;
                if (valid_pixel !== ev2[i]) begin
                    errors++;
                    $display("FAIL fill_s%0d yv=%0d: got valid=%0b, expected %0b",
                             scale, yv2[i], valid_pixel, ev2[i]);
                end
            end
        end
    endtask

    task automatic test_window();
        logic [10:0] xs [9];
        logic [9:0]  ys [9];
        logic        vs [9];
        logic        es [9];
        xs = '{11'd262, 11'd260, 11'd760, 11'd762, 11'd255, 11'd768, 11'd300, 11'd300, 11'd300};
        ys = '{10'd200, 10'd200, 10'd200, 10'd200, 10'd200, 10'd200, 10'd712, 10'd200, 10'd200};
        vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        es = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ch_enable = 2'b01; ch_fill = 2'b01; scale = 2'd2;
        read_value = {8'd0, 8'd200};
        for (int i = 0; i < 9; i++) begin
            x = xs[i]; y = ys[i]; valid = vs[i];
            step();
            vectors++;
            if (valid_pixel !== es[i]) begin
                errors++;
                $display("FAIL window x=%0d y=%0d v=%0b: got valid=%0b, expected %0b",
                         xs[i], ys[i], vs[i], valid_pixel, es[i]);
            end
        end
    endtask

    task automatic test_capture();
        int   yvs [3];
        logic evs [3];
        yvs = '{97, 63, 64};
        evs = '{1'b0, 1'b0, 1'b1};
        ch_enable = 2'b01; ch_fill = 2'b00; scale = 2'd0;
        load(11'd336, {8'd0, 8'd64});
        load(11'd338, {8'd0, 8'd128});
        valid = 1'b1; y = 10'd192;
        for (int i = 0; i < 10; i++) begin
            read_value = {8'd0, 8'(i * 25)};
            step();
            vectors++;
            if (valid_pixel !== 1'b1) begin
                errors++;
                $display("FAIL capture_hold cyc=%0d: got valid=%0b, expected 1", i, valid_pixel);
            end
        end
        for (int i = 0; i < 3; i++) begin
            y = 10'(2 * yvs[i]);
            step();
            vectors++;
            if (valid_pixel !== evs[i]) begin
                errors++;
                $display("FAIL capture_held yv=%0d: got valid=%0b, expected %0b", yvs[i], valid_pixel, evs[i]);
            end
        end
        // Stale data on the address cycle, fresh data on the next one.
        x = 11'd340; y = 10'd80; read_value = {8'd0, 8'd128};
        step();
        vectors++;
        if (valid_pixel !== 1'b0) begin
            errors++;
            $display("FAIL capture_t0: got valid=%0b, expected 0", valid_pixel);
        end
        read_value = {8'd0, 8'd0};
        step();
        vectors++;
        if (valid_pixel !== 1'b0) begin
            errors++;
            $display("FAIL capture_t1: got valid=%0b, expected 0", valid_pixel);
        end
        step();
        vectors++;
        if (valid_pixel !== 1'b1) begin
            errors++;
            $display("FAIL capture_t2: got valid=%0b, expected 1", valid_pixel);
        end
    endtask

    task automatic test_reset_mid();
        x = 11'd340; y = 10'd80; valid = 1'b1;
        reset = 1'b1;
        step();
        vectors++;
        if (valid_pixel !== 1'b0 || {r, g, b} !== 24'h0) begin
            errors++;
            $display("FAIL midreset_out: got valid=%0b rgb=%06h, expected 0/000000", valid_pixel, {r, g, b});
        end
        reset = 1'b0; y = 10'd0; read_value = {8'd0, 8'd0};
        step();
        vectors++;
        if (valid_pixel !== 1'b1 || {r, g, b} !== 24'h0000FF) begin
            errors++;
            $display("FAIL midreset_row0: got valid=%0b rgb=%06h, expected 1/0000FF", valid_pixel, {r, g, b});
        end
        y = 10'd2;
        step();
        vectors++;
        if (valid_pixel !== 1'b0) begin
            errors++;
            $display("FAIL midreset_row1: got valid=%0b, expected 0", valid_pixel);
        end
        step();
        step();
        read_index = 1'b1; read_value = {8'd0, 8'd128}; y = 10'd180;
        #1;
        vectors++;
        if (read_address !== 9'd298) begin
            errors++;
            $display("FAIL toggle_addr: got %0d, expected 298", read_address);
        end
        step();
        vectors++;
        if (valid_pixel !== 1'b0) begin
            errors++;
            $display("FAIL toggle_t0: got valid=%0b, expected 0", valid_pixel);
        end
        step();
        vectors++;
        if (valid_pixel !== 1'b0) begin
            errors++;
            $display("FAIL toggle_t1: got valid=%0b, expected 0", valid_pixel);
        end
        step();
        vectors++;
        if (valid_pixel !== 1'b1) begin
            errors++;
            $display("FAIL toggle_t2: got valid=%0b, expected 1", valid_pixel);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_priority();
        test_fill();
        test_window();
        test_capture();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
